jt49_eg_sched: RTL
==================

// Module: jt49_eg_sched
// PURPOSE
//  Envelope scheduler for the PSG: decodes CPU writes to the envelope registers
//  (fine period, coarse period, shape), runs the envelope period prescaler/counter
//  and drives step/null_period/restart/ctrl into the envelope generator.
//  Sits between the register-write path and the EG inside the core; owns all
//  envelope timing so the EG only reacts to strobes.
// PARAMETERS
//  PRESCALE  8   cen ticks per period-counter tick; legal range 2..256
//  PW        16  envelope period width, bits
// PORTS
//  clk            in   1   core clock
//  rst_n          in   1   asynchronous reset, active low
//  cen            in   1   clock enable; all timing below counts cen-qualified cycles
//  wr             in   1   register write strobe, one clk wide, sampled every clk
//  addr           in   4   register address
//  din            in   8   write data
//  eg_step        out  1   one-cen-wide step pulse to EG
//  eg_null_period out  1   high while period==0
//  eg_restart     out  1   envelope restart request to EG
//  eg_ctrl        out  4   shape {CONT,ATT,ALT,HOLD}
//  period         out  PW  current period {coarse,fine}
// BEHAVIOUR
//  Clock/reset: one clock, clk; rst_n asynchronous, active low.
//  - Reset values: eg_step=0, eg_null_period=1, eg_restart=0, eg_ctrl=0,
//    period=0, prescaler=0, counter=0, FSM=RUN.
//  - Writes, accepted on any clk regardless of cen:
//    ADDR_FINE(4'hB) -> period[7:0]; ADDR_COARSE(4'hC) -> period[15:8];
//    ADDR_SHAPE(4'hD) -> eg_ctrl<=din[3:0], FSM->RESTART; other addresses ignored.
//    New value is visible on period/eg_ctrl the clk after wr.
//  - eg_null_period: registered (period==0); updates the clk after the write.
//  - tick = cen && pre==PRESCALE-1; pre increments on cen and wraps to 0.
//  - On tick in RUN: if period!=0 && cnt>=period-1, then cnt<=0 and expire;
//    else cnt<=cnt+1 saturating at all-ones. The >= compare lets a period
//    shortened below cnt expire on the very next tick, with no wrap.
//  - eg_step <= tick && expire, updated on every cen. It is high for exactly one
//    cen-qualified cycle, and PRESCALE>=2 guarantees a low cen in between, so
//    the EG sees one rising edge per expiry. Step interval = period*PRESCALE cen.
//  - period==0: counter held at 0; eg_step stays 0; EG is driven by null_period.
//  - Period writes do not clear cnt/pre; the change takes effect at the next tick.
//  - FSM:
//    RUN: normal counting; shape write -> RESTART.
//    RESTART: eg_restart=1 (registered, rises the clk after wr); pre, cnt and
//      eg_step forced to 0. Leaves to RUN on the first cen seen while in RESTART,
//      with eg_restart low the following clk.
//  - A shape write while in RESTART updates eg_ctrl and stays in RESTART.
//  - Shape and period writes never coincide (single wr port). A write in the
//    same clk as tick: the write lands, and the tick uses the old period.
//  - rst_n low at any time, including in RESTART, forces reset values at once;
//    no restart is replayed after release.
// STRUCTURE
//  - jt49_eg_pkg: ADDR_FINE/ADDR_COARSE/ADDR_SHAPE localparams and the state
//    encoding (RUN=1'b0, RESTART=1'b1).
//  - One sub-module, jt49_eg_div: prescaler + period counter. Inputs: cen,
//    clear, period. Output: expire. Top holds register decode, FSM, outputs.
// TESTING
//  1 Reset, no writes -> eg_null_period=1, eg_step=0, eg_restart=0, eg_ctrl=0, period=0.
//  2 cen every clk, write B=3, C=0 -> eg_step pulses every 24 cen, width 1 cen.
//  3 period=3 counting; write D=0xE mid-count, cen every 4 clk -> eg_restart high
//    from wr+1 until the clk after next cen; eg_ctrl=4'hE; first step 24 cen later.
//  4 period=0 for 1000 cen -> no eg_step, null_period=1; write B=1 -> null_period
//    falls next clk, step every 8 cen.
//  5 period=100, wait for cnt=50, write B=2 -> eg_step on the very next tick,
//    then every 16 cen.
//  6 Assert rst_n low while in RESTART -> eg_restart, eg_ctrl, period cleared
//    asynchronously; after release, no restart pulse and null_period=1.

Source files
------------

// File: rtl/jt49_eg_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : jt49_eg_pkg
// Brief  : Shared definitions for the PSG envelope scheduler: the register
//          addresses it decodes and the scheduler state encoding.
// Ports  : none (package)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package jt49_eg_pkg;

   localparam logic [3:0] ADDR_FINE   = 4'hB;
   localparam logic [3:0] ADDR_COARSE = 4'hC;
   localparam logic [3:0] ADDR_SHAPE  = 4'hD;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RESTART = 1'b1
   } eg_state_t;

endpackage
`default_nettype wire

// File: rtl/jt49_eg_div.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : jt49_eg_div
// Brief  : Envelope prescaler plus period counter. Produces a single-cycle
//          expire strobe each time the counter reaches the envelope period.
// Ports  : clk     in   core clock
//          rst_n   in   asynchronous reset, active low
//          cen     in   clock enable
//          clear   in   hold prescaler and counter at zero
//          period  in   envelope period (0 = stopped)
//          expire  out  tick that completes a period (combinational)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module jt49_eg_div #(
   parameter int PRESCALE = 8,
   parameter int PW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          clear,
   input  logic [PW-1:0] period,
   output logic          expire
);

   localparam int              PRE_W    = $clog2(PRESCALE);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic             tick_w;
   logic             hit_w;

   assign tick_w = cen && (pre_q == PRE_LAST);

   // Greater-or-equal so that shortening the period below the current count
   // expires on the next tick instead of wrapping through all-ones.
   assign hit_w  = (period != '0) && (cnt_q >= (period - PW'(1)));

   assign expire = tick_w && hit_w && !clear;

   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      if (clear) begin
         pre_d = '0;
         cnt_d = '0;
      end else begin
         if (cen) begin
            pre_d = tick_w ? '0 : pre_q + PRE_W'(1);
         end
         if (period == '0) begin
            cnt_d = '0;
         end else if (tick_w) begin
            if (hit_w) begin
               cnt_d = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/jt49_eg_sched.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : jt49_eg_sched
// Brief  : PSG envelope scheduler. Decodes envelope register writes, owns the
//          envelope timing and hands the EG simple strobes.
// Ports  : clk            in   core clock
//          rst_n          in   asynchronous reset, active low
//          cen            in   clock enable
//          wr             in   register write strobe
//          addr           in   register address
//          din            in   write data
//          eg_step        out  one-cen-wide step pulse
//          eg_null_period out  period is zero
//          eg_restart     out  envelope restart request
//          eg_ctrl        out  shape {CONT,ATT,ALT,HOLD}
//          period         out  current period {coarse,fine}
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module jt49_eg_sched
   import jt49_eg_pkg::*;
#(
   parameter int PRESCALE = 8,
   parameter int PW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          wr,
   input  logic [3:0]    addr,
   input  logic [7:0]    din,
   output logic          eg_step,
   output logic          eg_null_period,
   output logic          eg_restart,
   output logic [3:0]    eg_ctrl,
   output logic [PW-1:0] period
);

   eg_state_t     state_q, state_d;
   logic [PW-1:0] period_q, period_d;
   logic [3:0]    ctrl_q, ctrl_d;
   logic          null_q;
   logic          step_q, step_d;
   logic          shape_wr_w;
   logic          expire_w;
   logic          clear_w;

   assign shape_wr_w = wr && (addr == ADDR_SHAPE);
   assign clear_w    = (state_q == ST_RESTART);

   // Register decode
   always_comb begin
      period_d = period_q;
      ctrl_d   = ctrl_q;
      if (wr) begin
         case (addr)
            ADDR_FINE:   period_d[7:0]    = din;
            ADDR_COARSE: period_d[PW-1:8] = din[PW-9:0];
            ADDR_SHAPE:  ctrl_d           = din[3:0];
            default:     ;
         endcase
      end
   end

   // Scheduler FSM; the restart request lasts until the first cen it sees
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (shape_wr_w) state_d = ST_RESTART;
         end
         ST_RESTART: begin
            if (!shape_wr_w && cen) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      step_d = step_q;
      if (clear_w) begin
         step_d = 1'b0;
      end else if (cen) begin
         step_d = expire_w;
      end
   end

   jt49_eg_div #(
      .PRESCALE (PRESCALE),
      .PW       (PW)
   ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .cen    (cen),
      .clear  (clear_w),
      .period (period_q),
      .expire (expire_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         period_q <= '0;
         ctrl_q   <= '0;
         null_q   <= 1'b1;
         step_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         ctrl_q   <= ctrl_d;
         // Built from the next period so it tracks period with no extra lag
         null_q   <= (period_d == '0);
         step_q   <= step_d;
      end
   end

   assign eg_step        = step_q;
   assign eg_null_period = null_q;
   assign eg_restart     = (state_q == ST_RESTART);
   assign eg_ctrl        = ctrl_q;
   assign period         = period_q;

endmodule
`default_nettype wire
